// File: rtl/mem_pkg.sv
// Shared memory-side types and constants for the cache/backing-store slice.
// Block geometry is common to the cache and the main memory model.
package mem_pkg;

    localparam int WORD_SIZE       = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int BLOCK_SIZE      = WORDS_PER_BLOCK * WORD_SIZE;
    localparam int MEM_BLOCKS      = 256;
    localparam int ADDR_WIDTH      = $clog2(MEM_BLOCKS);

    typedef enum logic [1:0] {
        IDLE,
        WR_WAIT,
        RD_WAIT,
        RD_RESP
    } mem_state_t;

    // Reduce a wide {tag,index} block address into the stored range.
    function automatic logic [ADDR_WIDTH-1:0] to_block_addr(
        input logic [31:0] a
    );
        return ADDR_WIDTH'(a % MEM_BLOCKS);
    endfunction

endpackage

// File: rtl/main_memory_model_if.sv
// Cache <-> main memory block-transfer bus.
// The cache controller is the master; the memory model is the slave.
interface main_memory_model_if #(
    parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
    parameter int BLOCK_SIZE = mem_pkg::BLOCK_SIZE
) ();

    logic                  read_en_mem;
    logic                  write_en_mem;
    logic [ADDR_WIDTH-1:0] block_addr;
    logic [BLOCK_SIZE-1:0] wdata_block;
    logic                  ready_mem;
    logic                  valid_mem;
    logic [BLOCK_SIZE-1:0] rdata_block;
    logic                  busy;

    modport master (
        output read_en_mem,
        output write_en_mem,
        output block_addr,
        output wdata_block,
        input  ready_mem,
        input  valid_mem,
        input  rdata_block,
        input  busy
    );

    modport slave (
        input  read_en_mem,
        input  write_en_mem,
        input  block_addr,
        input  wdata_block,
        output ready_mem,
        output valid_mem,
        output rdata_block,
        output busy
    );

endinterface

// File: rtl/latency_counter.sv
// Loadable down-counter with zero flag, shared by the read and write paths.
// Saturates at zero so a stray decrement never wraps.
module latency_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/main_memory_model.sv
// Backing store behind the direct-mapped cache: one block per transfer,
// programmable read/write latency, strictly serialised requests.
module main_memory_model #(
    parameter int WORD_SIZE       = mem_pkg::WORD_SIZE,
    parameter int WORDS_PER_BLOCK = mem_pkg::WORDS_PER_BLOCK,
    parameter int BLOCK_SIZE      = WORDS_PER_BLOCK * WORD_SIZE,
    parameter int MEM_BLOCKS      = 256,
    parameter int ADDR_WIDTH      = $clog2(MEM_BLOCKS),
    parameter int READ_LATENCY    = 4,
    parameter int WRITE_LATENCY   = 3
) (
    input  logic                clk,
    input  logic                rst,
    main_memory_model_if.slave  mem_bus
);

    import mem_pkg::*;

    localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ?
                             READ_LATENCY : WRITE_LATENCY;
    localparam int CW = $clog2(LAT_MAX) + 1;

    localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

    mem_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [BLOCK_SIZE-1:0] data_q;
    logic [BLOCK_SIZE-1:0] rdata_q;
    logic [BLOCK_SIZE-1:0] mem [MEM_BLOCKS];

    logic          cnt_load;
    logic [CW-1:0] cnt_val;
    logic          cnt_dec;
    logic          cnt_zero;
    logic          acc_wr;
    logic          acc_rd;
    logic          wr_commit;
    logic          rd_fetch;

    assign addr_in = ADDR_WIDTH'(32'(mem_bus.block_addr) % 32'(MEM_BLOCKS));

    latency_counter #(.CW(CW)) u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
        acc_wr    = 1'b0;
        acc_rd    = 1'b0;
        wr_commit = 1'b0;
        rd_fetch  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Write-back wins; a level-held read is taken next IDLE.
                priority case (1'b1)
                    mem_bus.write_en_mem: begin
                        acc_wr   = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = WR_LOAD;
                        state_d  = WR_WAIT;
                    end
                    mem_bus.read_en_mem: begin
                        acc_rd   = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = RD_LOAD;
                        state_d  = RD_WAIT;
                    end
                    default: ;
                endcase
            end
            WR_WAIT: begin
                if (cnt_zero) begin
                    wr_commit = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RD_WAIT: begin
                if (cnt_zero) begin
                    rd_fetch = 1'b1;
                    state_d  = RD_RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RD_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (acc_wr || acc_rd) begin
                addr_q <= addr_in;
            end
            if (acc_wr) begin
                data_q <= mem_bus.wdata_block;
            end
        end
    end

    // Storage is deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[addr_q] <= data_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (rd_fetch) begin
            rdata_q <= mem[addr_q];
        end
    end

    assign mem_bus.ready_mem   = (state_q == IDLE);
    assign mem_bus.busy        = (state_q != IDLE);
    assign mem_bus.valid_mem   = (state_q == RD_RESP);
    assign mem_bus.rdata_block = rdata_q;

endmodule

// File: tb/tb_main_memory_model.sv
// Scoreboard bench for main_memory_model: latency, priority, wrap,
// reset abort and a cache dirty-miss sequence.
module tb_main_memory_model;

    import mem_pkg::*;

    localparam int AW = ADDR_WIDTH;
    localparam int BS = BLOCK_SIZE;
    localparam int RL = 4;
    localparam int WL = 3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    main_memory_model_if #(.ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) bus ();

    main_memory_model #(
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clk     (clk),
        .rst     (rst_n),
        .mem_bus (bus)
    );

    int n_tests   = 0;
    int n_fail    = 0;
    int valid_cnt = 0;
    int wr_acc    = 0;
    logic valid_prev   = 1'b0;
    logic cache_active = 1'b0;
    logic done_cache;

    logic [BS-1:0] exp_q [$];
    logic [BS-1:0] model [int];

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Refill monitor: every valid_mem pulse pops one expected block.
    always @(negedge clk) begin
        if (bus.valid_mem) begin
            valid_cnt++;
            chk("valid_width", {127'd0, valid_prev}, 128'd0);
            if (exp_q.size() == 0) begin
                chk("valid_unexpected", 128'd1, 128'd0);
            end else begin
                chk("rdata", bus.rdata_block, exp_q.pop_front());
            end
        end
        valid_prev = bus.valid_mem;
    end

    always @(posedge clk) begin
        if (bus.write_en_mem && bus.ready_mem && rst_n) begin
            wr_acc++;
        end
    end

    // Cache controller finishes the miss one cycle after the refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cache <= 1'b0;
        end else begin
            done_cache <= cache_active && bus.valid_mem;
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, {127'd0, bus.ready_mem}, 128'd1);
        chk({tag, "_valid"}, {127'd0, bus.valid_mem}, 128'd0);
        chk({tag, "_busy"}, {127'd0, bus.busy}, 128'd0);
        chk({tag, "_rdata"}, bus.rdata_block, 128'd0);
    endtask

    task automatic wait_ready(output int lows);
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.ready_mem) return;
            lows++;
        end
        chk("ready_timeout", 128'd0, 128'd1);
    endtask

    task automatic rd_tail();
        int edges;
        int lows;
        edges = 1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            edges++;
            #1;
            if (bus.valid_mem) break;
        end
        chk("rd_latency", 128'(edges), 128'(RL + 1));
        if (cache_active) begin
            chk("done_early", {127'd0, done_cache}, 128'd0);
            @(posedge clk);
            #1;
            chk("done_cache", {127'd0, done_cache}, 128'd1);
        end
        wait_ready(lows);
    endtask

    task automatic write_blk(input logic [AW-1:0] a, input logic [BS-1:0] d);
        int lows;
        @(negedge clk);
        bus.write_en_mem = 1'b1;
        bus.block_addr   = a;
        bus.wdata_block  = d;
        @(posedge clk);
        #1;
        bus.write_en_mem = 1'b0;
        wait_ready(lows);
        chk("wr_ready_low", 128'(lows), 128'(WL));
        model[int'(a)] = d;
    endtask

    task automatic read_blk(input logic [AW-1:0] a);
        @(negedge clk);
        bus.read_en_mem = 1'b1;
        bus.block_addr  = a;
        exp_q.push_back(model[int'(a)]);
        @(posedge clk);
        #1;
        bus.read_en_mem = 1'b0;
        rd_tail();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lows;
        int v0;
        int a0;
        logic [BS-1:0] pat;

        bus.read_en_mem  = 1'b0;
        bus.write_en_mem = 1'b0;
        bus.block_addr   = '0;
        bus.wdata_block  = '0;
        rst_n = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("rst_hold");
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("rst_rel");

        write_blk(8'h12, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
        read_blk(8'h12);

        // Both requests together: write first, held read follows.
        @(negedge clk);
        bus.write_en_mem = 1'b1;
        bus.read_en_mem  = 1'b1;
        bus.block_addr   = 8'h05;
        bus.wdata_block  = {16{8'hA5}};
        @(posedge clk);
        #1;
        bus.write_en_mem = 1'b0;
        wait_ready(lows);
        chk("simul_wr_low", 128'(lows), 128'(WL));
        model[5] = {16{8'hA5}};
        exp_q.push_back(model[5]);
        @(posedge clk);
        #1;
        bus.read_en_mem = 1'b0;
        rd_tail();

        // Read pulse during WR_WAIT is dropped; 0x105 wraps to 0x05.
        pat = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        v0 = valid_cnt;
        @(negedge clk);
        bus.write_en_mem = 1'b1;
        bus.block_addr   = to_block_addr(32'h105);
        bus.wdata_block  = pat;
        @(posedge clk);
        #1;
        bus.write_en_mem = 1'b0;
        @(negedge clk);
        bus.read_en_mem = 1'b1;
        @(posedge clk);
        #1;
        bus.read_en_mem = 1'b0;
        wait_ready(lows);
        chk("ign_wr_low", 128'(lows), 128'(WL - 1));
        model[5] = pat;
        repeat (8) @(negedge clk);
        chk("ign_no_valid", 128'(valid_cnt - v0), 128'd0);
        read_blk(8'h05);

        // Reset in WR_WAIT cycle 2 drops the write.
        write_blk(8'h20, {32{4'h1}});
        @(negedge clk);
        bus.write_en_mem = 1'b1;
        bus.block_addr   = 8'h20;
        bus.wdata_block  = {32{4'hF}};
        @(posedge clk);
        #1;
        bus.write_en_mem = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("wr_rst_ready", {127'd0, bus.ready_mem}, 128'd1);
        chk("wr_rst_busy", {127'd0, bus.busy}, 128'd0);
        @(negedge clk);
        chk("wr_rst_rdata", bus.rdata_block, 128'd0);
        rst_n = 1'b1;
        read_blk(8'h20);

        // Reset in RD_WAIT: no response may follow.
        v0 = valid_cnt;
        @(negedge clk);
        bus.read_en_mem = 1'b1;
        bus.block_addr  = 8'h12;
        @(posedge clk);
        #1;
        bus.read_en_mem = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rd_rst_ready", {127'd0, bus.ready_mem}, 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rd_rst_no_valid", 128'(valid_cnt - v0), 128'd0);

        // Dirty miss: evict 0x33, refill from 0x44.
        write_blk(8'h44, 128'h44444444_55555555_66666666_77777777);
        cache_active = 1'b1;
        a0 = wr_acc;
        write_blk(8'h33, 128'h33333333_CCCCCCCC_99999999_00000000);
        read_blk(8'h44);
        chk("miss_wr_acc", 128'(wr_acc - a0), 128'd1);
        cache_active = 1'b0;
        read_blk(8'h33);

        repeat (3) @(negedge clk);
        chk("sb_empty", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/main_memory_model.md
Name: main_memory_model

Overview:
- Backing-store model that sits directly downstream of the direct-mapped cache.
- Accepts single-block write-backs (dirty evictions) and single-block refill reads from the cache controller.
- Each transfer completes after a programmable latency, over the existing ready_mem / valid_mem handshake.
- Provides the data_out_mem block that the cache consumes on refill.

Parameters:
- WORD_SIZE, 32, bits per word
- WORDS_PER_BLOCK, 4, words per block
- BLOCK_SIZE, WORDS_PER_BLOCK*WORD_SIZE, bits per transfer
- MEM_BLOCKS, 256, number of blocks stored
- ADDR_WIDTH, $clog2(MEM_BLOCKS), block-address width
- READ_LATENCY, 4, cycles from read acceptance to valid_mem (must be >=1)
- WRITE_LATENCY, 3, cycles from write acceptance to commit and ready_mem reassertion (must be >=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
- read_en_mem  in  1  refill request, level; sampled only in IDLE
- write_en_mem  in  1  write-back request, level; sampled only in IDLE
- block_addr  in  ADDR_WIDTH  block address: {tag,index} truncated to the low ADDR_WIDTH bits
- wdata_block  in  BLOCK_SIZE  dirty block from the cache (dirty_block_out)
- ready_mem  out  1  high only in IDLE; a request is accepted when it is high
- valid_mem  out  1  one-cycle pulse; rdata_block is valid in that cycle
- rdata_block  out  BLOCK_SIZE  refill data (data_out_mem)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - state=IDLE, ready_mem=1, valid_mem=0, busy=0, rdata_block=0, latency counter=0.
  - Storage array is not reset; contents are preserved across reset.
- States: IDLE, WR_WAIT, RD_WAIT, RD_RESP.
- IDLE:
  - write_en_mem=1 → latch block_addr and wdata_block, load counter=WRITE_LATENCY-1, go to WR_WAIT.
  - Otherwise read_en_mem=1 → latch block_addr, load counter=READ_LATENCY-1, go to RD_WAIT.
  - Write has priority when both are high; the read stays pending because it is level-held and is taken on the next IDLE cycle.
- WR_WAIT:
  - ready_mem=0.
  - Counter decrements each cycle.
  - At counter==0: mem[addr] <= latched data, go to IDLE. ready_mem is 1 in the following cycle.
  - Total ready_mem-low time = WRITE_LATENCY cycles.
- RD_WAIT:
  - ready_mem=0.
  - At counter==0: rdata_block <= mem[addr], go to RD_RESP.
- RD_RESP:
  - valid_mem=1 for exactly one cycle, then go to IDLE.
  - rdata_block holds its value until the next read response or reset.
- Read latency: acceptance edge to valid_mem high is READ_LATENCY+1 edges (READ_LATENCY wait cycles plus the response cycle).
- Requests arriving while not in IDLE are ignored; they are not queued.
- Read-after-write to the same address returns the newly written block, because transfers are strictly serialised.
- Width rules:
  - block_addr is used modulo MEM_BLOCKS.
  - Counter width is $clog2(max(READ_LATENCY,WRITE_LATENCY))+1. The counter does not wrap below 0.
- Reset mid-operation:
  - In WR_WAIT: the pending write is dropped and memory is unchanged.
  - In RD_WAIT or RD_RESP: no valid_mem is issued.
  - The block returns to IDLE with ready_mem=1 asynchronously.
- Storage is a single-port array: one write per cycle, synchronous read into the rdata_block register.

Decomposition:
- Package mem_pkg:
  - mem_state_t enum {IDLE, WR_WAIT, RD_WAIT, RD_RESP}, logic [1:0].
  - Shared constants WORD_SIZE, WORDS_PER_BLOCK, BLOCK_SIZE, used by cache and memory.
  - Helper function for block-address truncation.
- Sub-module latency_counter:
  - Load value, decrement, and zero flag.
  - Async active-low reset.
  - Reused by the read and write paths.

Test Plan:
- Reset check: hold rst=0 for 3 cycles, then release → ready_mem=1, valid_mem=0, busy=0, rdata_block=0 throughout and after release.
- Write then read, defaults: write addr 0x12 data 0xDEADBEEF_CAFEF00D_01234567_89ABCDEF → ready_mem low exactly 3 cycles. Then read addr 0x12 → valid_mem pulses high for exactly 1 cycle, 5 edges after acceptance, with the written data.
- Simultaneous request: read_en_mem=1 and write_en_mem=1 in IDLE, addr 0x05 data 0xA5…A5 → write is taken first. Read is held high and accepted on the following IDLE cycle, returning 0xA5…A5 (same-address read-after-write).
- Ignored request plus address wrap: pulse read_en_mem for one cycle during WR_WAIT → no valid_mem. Write to addr 0x105 with MEM_BLOCKS=256 → a read of addr 0x05 returns that data.
- Reset mid-write: assert rst at WR_WAIT cycle 2 of a write of 0xFFFF…F to addr 0x20, where addr 0x20 previously held 0x1111…1 → read of 0x20 returns 0x1111…1. ready_mem goes to 1 immediately on reset.
- Reset mid-read plus cache integration: reset during RD_WAIT → no valid_mem pulse. Then drive a cache-controller dirty miss → write_en_mem accepted for 1 cycle, followed by a refill read with valid_mem, and done_cache asserted one cycle after valid_mem.
